gpio_input_debounce: RTL and testbench
======================================

// Module: gpio_input_debounce
// PURPOSE
//  Conditions raw board button inputs before they reach the slurm16 core's INPUT_PINS port.
//  Per channel it provides a 2-flop synchroniser, a counter-based debouncer and rise/fall edge pulses.
//  Sticky event-pending bits and a combined IRQ line let firmware poll, or take an interrupt on, button presses.
//  Sits in the iCE40 top level between the button pads and the CPU input port, in the PLL clock domain.
// PARAMETERS
//  NUM_INPUTS       8          number of input channels
//  DEBOUNCE_CYCLES  251250     cycles an input must stay stable to be accepted (10 ms @ 25.125 MHz); >=2
//  RESET_LEVEL      8'h00      reset value of sync flops and debounced outputs, per bit (NUM_INPUTS wide)
// PORTS
//  CLK          in   1           system clock (PLL output)
//  RSTb         in   1           asynchronous active-low reset
//  PINS_IN      in   NUM_INPUTS  raw asynchronous pad inputs
//  PINS_OUT     out  NUM_INPUTS  debounced levels -> slurm16 INPUT_PINS
//  RISE         out  NUM_INPUTS  1-cycle pulse when a debounced bit goes 0->1
//  FALL         out  NUM_INPUTS  1-cycle pulse when a debounced bit goes 1->0
//  RISE_EN      in   NUM_INPUTS  per-bit: rising edge sets PENDING
//  FALL_EN      in   NUM_INPUTS  per-bit: falling edge sets PENDING
//  PEND_CLR     in   NUM_INPUTS  per-bit: write-1 clear of PENDING (level, sampled each cycle)
//  PENDING      out  NUM_INPUTS  sticky event flags
//  IRQ          out  1           OR of PENDING, registered
// BEHAVIOUR
//  - Reset (RSTb=0, async):
//    - sync1/sync2/PINS_OUT = RESET_LEVEL
//    - counters = 0; RISE = FALL = PENDING = 0; IRQ = 0
//  - Synchroniser: sync1 <= PINS_IN; sync2 <= sync1. Only sync2 is used downstream.
//  - Debounce, per channel i, counter width $clog2(DEBOUNCE_CYCLES):
//    - sync2[i] == PINS_OUT[i]: cnt <= 0 (any glitch restarts the window)
//    - differs, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1
//    - differs, cnt == DEBOUNCE_CYCLES-1: PINS_OUT[i] <= sync2[i]; cnt <= 0;
//      same edge RISE[i]/FALL[i] <= 1 for exactly one cycle
//    - Counter never wraps; it saturates at the accept point and clears.
//  - Latency: a clean step on PINS_IN appears on PINS_OUT after 2 + DEBOUNCE_CYCLES clock edges.
//    RISE/FALL assert in the same cycle PINS_OUT changes.
//  - A pulse shorter than DEBOUNCE_CYCLES cycles (post-sync) never reaches PINS_OUT.
//  - PENDING[i] next = (PENDING[i] & ~PEND_CLR[i]) | (RISE[i]&RISE_EN[i]) | (FALL[i]&FALL_EN[i]);
//    evaluated on the registered RISE/FALL, so PENDING sets one cycle after the pulse.
//    On simultaneous clear and set, set wins.
//  - IRQ <= |PENDING_next. IRQ stays high while any bit is pending and drops the cycle after the last clear.
//  - Channels are fully independent; simultaneous edges on several bits are all captured.
//  - Reset mid-debounce discards the partial count.
//    After release, PINS_OUT = RESET_LEVEL; an input already at the opposite level
//    re-qualifies after 2 + DEBOUNCE_CYCLES cycles and produces an edge.
// TESTING (bench uses DEBOUNCE_CYCLES=4, NUM_INPUTS=8, RESET_LEVEL=8'h00)
//  - Reset: hold RSTb=0, PINS_IN=8'hFF -> all outputs 0.
//    Release -> PINS_OUT=8'hFF exactly 6 cycles later, RISE=8'hFF for 1 cycle, no PENDING while RISE_EN=0.
//  - Bounce: PINS_IN[0] toggles 1,0,1 with 2-cycle widths, then holds 1 -> exactly one RISE[0] pulse;
//    PINS_OUT[0] rises 6 cycles after the final edge.
//  - Glitch: 3-cycle high pulse on PINS_IN[3] -> PINS_OUT[3], RISE[3], PENDING[3] all stay 0.
//  - Events: RISE_EN=8'h01, FALL_EN=8'h02, press and release bits 0 and 1 ->
//    PENDING=8'h01 after bit0 rise, 8'h03 after bit1 fall; IRQ=1; PEND_CLR=8'h03 for 1 cycle -> PENDING=0, IRQ=0 next cycle.
//  - Set/clear collision: hold PEND_CLR[0]=1 in the cycle an enabled RISE[0] is registered -> PENDING[0]=1 afterwards.
//  - Reset mid-debounce: assert RSTb=0 with cnt=2 on bit 5 -> after release no stale edge;
//    bit 5 re-qualifies in 6 cycles.

Source files
------------

// File: rtl/gpio_input_debounce.sv
// Button input conditioning: 2-flop synchroniser, per-channel counter debouncer,
// registered rise/fall pulses, sticky pending flags and a combined interrupt line.
module gpio_input_debounce #(
    parameter int unsigned            NUM_INPUTS      = 8,
    parameter int unsigned            DEBOUNCE_CYCLES = 251250,
    parameter logic [NUM_INPUTS-1:0]  RESET_LEVEL     = '0
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic [NUM_INPUTS-1:0] PINS_IN,
    output logic [NUM_INPUTS-1:0] PINS_OUT,
    output logic [NUM_INPUTS-1:0] RISE,
    output logic [NUM_INPUTS-1:0] FALL,
    input  logic [NUM_INPUTS-1:0] RISE_EN,
    input  logic [NUM_INPUTS-1:0] FALL_EN,
    input  logic [NUM_INPUTS-1:0] PEND_CLR,
    output logic [NUM_INPUTS-1:0] PENDING,
    output logic                  IRQ
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
    // Count value at which a differing input is accepted.
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
    logic [NUM_INPUTS-1:0] level_q, level_d;
    logic [NUM_INPUTS-1:0] rise_q, rise_d;
    logic [NUM_INPUTS-1:0] fall_q, fall_d;
    logic [NUM_INPUTS-1:0] pend_q, pend_d;
    logic                  irq_q;
    logic [CntW-1:0]       cnt_q [NUM_INPUTS];
    logic [CntW-1:0]       cnt_d [NUM_INPUTS];

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= PINS_IN;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel stability counter; any sample matching the current level restarts the window.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Pending flags act on the registered edge pulses; a set in the same cycle as a clear wins.
    always_comb begin
        pend_d = (pend_q & ~PEND_CLR) | (rise_q & RISE_EN) | (fall_q & FALL_EN);
    end

    // Debounce state, edge pulses, pending flags and interrupt registers.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            level_q <= RESET_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            irq_q   <= |pend_d;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign PINS_OUT = level_q;
    assign RISE     = rise_q;
    assign FALL     = fall_q;
    assign PENDING  = pend_q;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Scoreboard bench for gpio_input_debounce: a reference model predicts every cycle's outputs,
// a monitor compares them against the DUT on the falling clock edge.
module tb_gpio_input_debounce;

    localparam int unsigned N  = 8;
    localparam int unsigned DC = 4;
    localparam logic [N-1:0] RL = 8'h00;

    logic         CLK = 1'b0;
    logic         RSTb;
    logic [N-1:0] PINS_IN, PINS_OUT, RISE, FALL, RISE_EN, FALL_EN, PEND_CLR, PENDING;
    logic         IRQ;

    gpio_input_debounce #(
        .NUM_INPUTS      (N),
        .DEBOUNCE_CYCLES (DC),
        .RESET_LEVEL     (RL)
    ) dut (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .PINS_IN  (PINS_IN),
        .PINS_OUT (PINS_OUT),
        .RISE     (RISE),
        .FALL     (FALL),
        .RISE_EN  (RISE_EN),
        .FALL_EN  (FALL_EN),
        .PEND_CLR (PEND_CLR),
        .PENDING  (PENDING),
        .IRQ      (IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] pend;
        logic         irq;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cycles = 0;

    // Reference model state: a two-deep delay line stands in for the synchroniser, and a
    // window of the most recent DC synchronised samples decides acceptance.
    logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_pend;
    logic         m_irq;
    logic [N-1:0] hist[$];

    task automatic model_reset();
        m_s1    = RL;
        m_s2    = RL;
        m_level = RL;
        m_rise  = '0;
        m_fall  = '0;
        m_pend  = '0;
        m_irq   = 1'b0;
        hist.delete();
    endtask

    // A channel flips when each of its last DC synchronised samples disagrees with its level.
    task automatic model_step();
        logic [N-1:0] sample, pend_new, nr, nf;
        bit           all_diff;
        sample = m_s2;
        m_s2   = m_s1;
        m_s1   = PINS_IN;
        hist.push_back(sample);
        if (hist.size() > DC) void'(hist.pop_front());
        pend_new = (m_pend & ~PEND_CLR) | (m_rise & RISE_EN) | (m_fall & FALL_EN);
        nr = '0;
        nf = '0;
        for (int i = 0; i < N; i++) begin
            all_diff = (hist.size() == DC);
            foreach (hist[j]) if (hist[j][i] == m_level[i]) all_diff = 0;
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                nr[i] = m_level[i];
                nf[i] = ~m_level[i];
            end
        end
        m_rise = nr;
        m_fall = nf;
        m_pend = pend_new;
        m_irq  = |pend_new;
    endtask

    // Predictor: inputs are stable across the rising edge, so read them there.
    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (!RSTb) model_reset();
            else model_step();
            exp_q.push_back('{level: m_level, rise: m_rise, fall: m_fall, pend: m_pend, irq: m_irq});
        end
    end

    task automatic cmp(string name, logic [N-1:0] act, logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycles, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered output set; pop and compare it.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            cycles++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cycles);
            end else begin
                e = exp_q.pop_front();
                cmp("pins_out", PINS_OUT, e.level);
                cmp("rise", RISE, e.rise);
                cmp("fall", FALL, e.fall);
                cmp("pending", PENDING, e.pend);
                cmp("irq", {7'b0, IRQ}, {7'b0, e.irq});
            end
        end
    end

    // Inputs change just after the falling edge, clear of both sampling points.
    task automatic step(int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    initial begin
        RSTb     = 1'b0;
        PINS_IN  = 8'hFF;
        RISE_EN  = '0;
        FALL_EN  = '0;
        PEND_CLR = '0;
        step(3);
        RSTb = 1'b1;
        step(10);
        // Release everything, then bounce bit 0 before holding it high.
        PINS_IN = 8'h00;
        step(10);
        PINS_IN[0] = 1'b1; step(2);
        PINS_IN[0] = 1'b0; step(2);
        PINS_IN[0] = 1'b1; step(10);
        // Short glitch on bit 3 must be filtered.
        PINS_IN[3] = 1'b1; step(3);
        PINS_IN[3] = 1'b0; step(10);
        // Event capture: rise on bit 0, fall on bit 1.
        PINS_IN = 8'h00; step(10);
        RISE_EN = 8'h01;
        FALL_EN = 8'h02;
        PINS_IN = 8'h03; step(10);
        PINS_IN = 8'h00; step(10);
        PEND_CLR = 8'h03; step(1);
        PEND_CLR = 8'h00; step(3);
        // Clear held in the same cycle a new enabled rise is registered.
        PINS_IN[0] = 1'b1; step(6);
        PEND_CLR[0] = 1'b1; step(1);
        PEND_CLR[0] = 1'b0; step(4);
        // Reset while bit 5 is partway through its window.
        PINS_IN[5] = 1'b1; step(4);
        RSTb = 1'b0; step(2);
        RSTb = 1'b1; step(12);
        // Randomised traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) PINS_IN = PINS_IN ^ N'($urandom());
            else if ($urandom_range(0, 1) == 0) PINS_IN[$urandom_range(0, N - 1)] ^= 1'b1;
            RISE_EN  = N'($urandom());
            FALL_EN  = N'($urandom());
            PEND_CLR = ($urandom_range(0, 4) == 0) ? N'($urandom()) : '0;
            RSTb     = ($urandom_range(0, 99) != 0);
            step($urandom_range(1, 8));
            RSTb = 1'b1;
        end
        step(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
